// File: rtl/twos_sub_sequencer.sv
// Purpose: sequential X - Y; negates Y through an external twos_compliment stage, then adds it to X.
// Latency: tc_ready first high at edge k+N after start at edge k -> done high in the cycle after edge k+N+2.
// Backpressure: start is accepted only while idle (busy low); requests made while busy are dropped, never queued.
module twos_sub_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             error,
  output logic             tc_en,
  output logic [WIDTH-1:0] tc_A,
  input  logic             tc_ready,
  input  logic [WIDTH-1:0] tc_Output
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NEGATE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic             accept, capture, abort;
  logic [WIDTH-1:0] x_q, y_q, neg_y;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  // The done pulse is registered one cycle behind the DONE state; busy spans it so
  // a new start cannot slip in while the previous result is being presented.
  assign busy = (state != S_IDLE) | done;
  assign sum  = {1'b0, x_q} + {1'b0, neg_y};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and the single-cycle control strobes for the datapath.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !done) begin
          accept   = 1'b1;
          state_nx = S_NEGATE;
        end
      end
      S_NEGATE: begin
        if (tc_ready) begin
          capture  = 1'b1;
          state_nx = S_ADD;
        end else if (cnt == CNT_LAST) begin
          abort    = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_ADD:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latching, negation handshake, timeout count and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      neg_y    <= '0;
      cnt      <= '0;
      tc_en    <= 1'b0;
      tc_A     <= '0;
      result   <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      error    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (accept) begin
        x_q   <= X;
        y_q   <= Y;
        tc_A  <= Y;
        tc_en <= 1'b1;
        cnt   <= '0;
      end
      if (state == S_NEGATE) begin
        if (capture) begin
          neg_y <= tc_Output;
          tc_en <= 1'b0;
        end else if (abort) begin
          tc_en    <= 1'b0;
          error    <= 1'b1;
          result   <= '0;
          zero     <= 1'b1;
          borrow   <= 1'b0;
          overflow <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == S_ADD) begin
        result   <= sum[WIDTH-1:0];
        // Y == 0 negates to 0 and never carries, yet X - 0 never borrows.
        borrow   <= (y_q != '0) & ~sum[WIDTH];
        overflow <= (x_q[WIDTH-1] != y_q[WIDTH-1]) & (sum[WIDTH-1] != x_q[WIDTH-1]);
        zero     <= (sum[WIDTH-1:0] == '0);
        error    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_twos_sub_sequencer.sv
module tb_twos_sub_sequencer;

  localparam int W   = 8;
  localparam int TO  = 16;
  localparam int NRD = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] X = '0, Y = '0;
  logic         busy, done, borrow, overflow, zero, error, tc_en;
  logic [W-1:0] result, tc_A;
  logic         tc_ready = 1'b0;
  logic [W-1:0] tc_Output = '0;

  typedef struct {
    logic [W-1:0] r;
    logic         b, o, z, e;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   done_cnt = 0;
  bit   hang = 1'b0;
  int   en_cnt = 0;

  twos_sub_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .result(result), .borrow(borrow),
    .overflow(overflow), .zero(zero), .error(error),
    .tc_en(tc_en), .tc_A(tc_A), .tc_ready(tc_ready), .tc_Output(tc_Output)
  );

  always #5 clk = ~clk;

  // Negation stub: ready rises so that it is first sampled NRD edges after tc_en rises.
  always @(negedge clk) begin
    if (tc_en && !hang) begin
      en_cnt    = en_cnt + 1;
      tc_ready  = (en_cnt >= NRD);
      tc_Output = 8'h00 - tc_A;
    end else begin
      en_cnt   = 0;
      tc_ready = 1'b0;
    end
  end

  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk = n_chk + 1;
    if (got === want) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    int   sd;
    sd  = int'($signed(x)) - int'($signed(y));
    m.r = x - y;
    m.b = (x < y);
    m.o = (sd < -128) || (sd > 127);
    m.z = (m.r == '0);
    m.e = 1'b0;
    return m;
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit hang_i, input bit poke);
    exp_t e, got_e;
    int   n, lat_want;
    hang = hang_i;
    if (hang_i) begin
      e.r = '0; e.b = 1'b0; e.o = 1'b0; e.z = 1'b1; e.e = 1'b1;
    end else begin
      e = model(x, y);
    end
    lat_want = hang_i ? (TO + 1) : (NRD + 2);
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_accept", 32'(busy), 1);
    chk("tc_en_accept", 32'(tc_en), 1);
    chk("tc_A_value", 32'(tc_A), 32'(y));
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n = n + 1;
      if (poke && n == 1) begin
        start = 1'b1; X = 8'hAA; Y = 8'h11;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 1);
    if (done) begin
      chk("latency", 32'(n), 32'(lat_want));
      chk("sb_nonempty", 32'(sb.size()), 1);
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        chk("result", 32'(result), 32'(got_e.r));
        chk("borrow", 32'(borrow), 32'(got_e.b));
        chk("overflow", 32'(overflow), 32'(got_e.o));
        chk("zero", 32'(zero), 32'(got_e.z));
        chk("error", 32'(error), 32'(got_e.e));
      end
      chk("tc_en_at_done", 32'(tc_en), 0);
      chk("busy_with_done", 32'(busy), 1);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_release", 32'(busy), 0);
    chk("result_held", 32'(result), 32'(e.r));
    hang = 1'b0;
  endtask

  initial begin
    int dc;
    logic [W-1:0] rx, ry;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tc_en", 32'(tc_en), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_result", 32'(result), 0);
    chk("rst_error", 32'(error), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(8'd20, 8'd12, 1'b0, 1'b0);
    run_op(8'd12, 8'd20, 1'b0, 1'b0);
    run_op(8'h55, 8'h55, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'd5,  8'd0,  1'b0, 1'b0);
    run_op(8'h00, 8'h80, 1'b0, 1'b0);
    run_op(8'h7F, 8'h80, 1'b0, 1'b0);

    // Start pulsed while busy must not produce a second result.
    dc = done_cnt;
    run_op(8'd100, 8'd1, 1'b0, 1'b1);
    repeat (8) @(posedge clk); #1;
    chk("busy_start_ignored", 32'(done_cnt - dc), 1);
    chk("idle_after_ignore", 32'(busy), 0);

    // Hung negation stage.
    run_op(8'd9, 8'd3, 1'b1, 1'b0);

    // Reset asserted while waiting in NEGATE.
    @(negedge clk); X = 8'd33; Y = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_tc_en", 32'(tc_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("midrst_no_done", 32'(done_cnt - dc), 0);
    chk("midrst_zero", 32'(zero), 1);
    run_op(8'd33, 8'd7, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rx = W'($urandom_range(0, 255));
      ry = W'($urandom_range(0, 255));
      run_op(rx, ry, 1'b0, 1'b0);
    end

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
